// File: rtl/cnn_pkg.sv
// ============================================================================
//  cnn_pkg -- shared FSM encoding, shift-port width and saturation bounds
//  Rev 1.0
// ============================================================================
`default_nettype none

package cnn_pkg;

    localparam int SHIFT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int sat_max(input int dw);
        return (2 ** (dw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int dw);
        return -(2 ** (dw - 1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/requant_sat.sv
// ============================================================================
//  requant_sat -- one element: rounding arithmetic shift, saturate, opt. ReLU
//  Optional feature macro: REQUANT_RELU_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module requant_sat
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_WIDTH  = 26
) (
    input  logic signed [BUF_WIDTH-1:0]  x,
    input  logic        [SHIFT_W-1:0]    shift,
    output logic signed [DATA_WIDTH-1:0] y
);

    localparam logic signed [BUF_WIDTH:0] MAX_V = (BUF_WIDTH+1)'(sat_max(DATA_WIDTH));
    localparam logic signed [BUF_WIDTH:0] MIN_V = (BUF_WIDTH+1)'(sat_min(DATA_WIDTH));

    logic signed [BUF_WIDTH:0] ext;
    logic signed [BUF_WIDTH:0] half;
    logic signed [BUF_WIDTH:0] rnd;
    logic signed [BUF_WIDTH:0] shr;

    // One guard bit keeps x + 2^(s-1) from wrapping at the top of the range.
    always_comb begin
        ext  = {x[BUF_WIDTH-1], x};
        half = '0;
        if (shift != '0) begin
            half = (BUF_WIDTH+1)'(1) << (shift - SHIFT_W'(1));
        end
        rnd = ext + half;
        shr = rnd >>> shift;
        if (shr > MAX_V) begin
            y = MAX_V[DATA_WIDTH-1:0];
        end else if (shr < MIN_V) begin
            y = MIN_V[DATA_WIDTH-1:0];
        end else begin
            y = shr[DATA_WIDTH-1:0];
        end
`ifdef REQUANT_RELU_EN
        if (y[DATA_WIDTH-1]) begin
            y = '0;
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/requant_pool.sv
// ============================================================================
//  requant_pool -- requantize conv accumulators, 2x2 max-pool, zero-pad output
//  Optional feature macro: REQUANT_RELU_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module requant_pool
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_WIDTH  = 26,
    parameter int MAP_SIZE   = 32,
    parameter int PADDING    = 1
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic                                                    start,
    input  logic [BUF_WIDTH*MAP_SIZE*MAP_SIZE-1:0]                  ofm_in,
    input  logic [SHIFT_W-1:0]                                      shift,
    output logic [DATA_WIDTH*(MAP_SIZE/2+2*PADDING)*(MAP_SIZE/2+2*PADDING)-1:0] ifm_out,
    output logic                                                    idle,
    output logic                                                    finish
);

    localparam int HALF     = MAP_SIZE / 2;
    localparam int P        = HALF + 2 * PADDING;
    localparam int ROW_BITS = 2 * MAP_SIZE * BUF_WIDTH;
    localparam int R_W      = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [R_W-1:0] R_LAST = R_W'(HALF - 1);

    state_t state, state_nx;
    logic   accept;

    logic [BUF_WIDTH*MAP_SIZE*MAP_SIZE-1:0] ibuf;
    logic [SHIFT_W-1:0]                     shift_q;
    logic [SHIFT_W-1:0]                     shift_c;
    logic [R_W-1:0]                         r;
    logic [ROW_BITS-1:0]                    rows;

    logic signed [DATA_WIDTH-1:0] q       [2*MAP_SIZE];
    logic signed [DATA_WIDTH-1:0] pm      [HALF];
    logic signed [DATA_WIDTH-1:0] pool_q  [HALF][HALF];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idle     = 1'b0;
        finish   = 1'b0;
        accept   = 1'b0;
        case (state)
            ST_IDLE: begin
                idle = 1'b1;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = ST_PROC;
                end
            end
            ST_PROC: begin
                if (r == R_LAST) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                finish   = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign shift_c = (int'(shift) >= BUF_WIDTH) ? SHIFT_W'(BUF_WIDTH - 1) : shift;
    assign rows    = ibuf[r*ROW_BITS +: ROW_BITS];

    // Requantizers cover input rows 2r (k < MAP_SIZE) and 2r+1 (k >= MAP_SIZE).
    for (genvar k = 0; k < 2 * MAP_SIZE; k++) begin : g_req
        requant_sat #(
            .DATA_WIDTH (DATA_WIDTH),
            .BUF_WIDTH  (BUF_WIDTH)
        ) u_rq (
            .x     (rows[k*BUF_WIDTH +: BUF_WIDTH]),
            .shift (shift_q),
            .y     (q[k])
        );
    end

    for (genvar c = 0; c < HALF; c++) begin : g_pool
        logic signed [DATA_WIDTH-1:0] top_max;
        logic signed [DATA_WIDTH-1:0] bot_max;
        assign top_max = (q[2*c] > q[2*c+1]) ? q[2*c] : q[2*c+1];
        assign bot_max = (q[MAP_SIZE+2*c] > q[MAP_SIZE+2*c+1]) ? q[MAP_SIZE+2*c]
                                                                : q[MAP_SIZE+2*c+1];
        assign pm[c]   = (top_max > bot_max) ? top_max : bot_max;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ibuf    <= '0;
            shift_q <= '0;
            r       <= '0;
            for (int i = 0; i < HALF; i++) begin
                for (int j = 0; j < HALF; j++) begin
                    pool_q[i][j] <= '0;
                end
            end
        end else if (accept) begin
            ibuf    <= ofm_in;
            shift_q <= shift_c;
            r       <= '0;
        end else if (state == ST_PROC) begin
            r <= r + R_W'(1);
            for (int c = 0; c < HALF; c++) begin
                pool_q[r][c] <= pm[c];
            end
        end
    end

    for (genvar i = 0; i < P; i++) begin : g_out_row
        for (genvar j = 0; j < P; j++) begin : g_out_col
            if (i >= PADDING && i < PADDING + HALF && j >= PADDING && j < PADDING + HALF) begin : g_in
                assign ifm_out[(P*i+j)*DATA_WIDTH +: DATA_WIDTH] = pool_q[i-PADDING][j-PADDING];
            end else begin : g_pad
                assign ifm_out[(P*i+j)*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_requant_pool.sv
// ============================================================================
//  tb_requant_pool -- randomized bench with a behavioural requant/pool model
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_requant_pool;

    localparam int DW   = 8;
    localparam int BW   = 26;
    localparam int MS   = 32;
    localparam int PAD  = 1;
    localparam int HALF = MS / 2;
    localparam int P    = HALF + 2 * PAD;
    localparam int LAT  = HALF + 1;

    logic                     clk;
    logic                     rst_n;
    logic                     start;
    logic [BW*MS*MS-1:0]      ofm_in;
    logic [4:0]               shift;
    logic [DW*P*P-1:0]        ifm_out;
    logic                     idle;
    logic                     finish;

    logic signed [BW-1:0] ofm_arr [MS][MS];
    logic signed [BW-1:0] cap_ofm [MS][MS];
    int                   cap_shift;
    int                   exp_cnt;
    int                   exp_res [P][P];

    int tests = 0;
    int fails = 0;

    requant_pool #(
        .DATA_WIDTH (DW),
        .BUF_WIDTH  (BW),
        .MAP_SIZE   (MS),
        .PADDING    (PAD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ofm_in  (ofm_in),
        .shift   (shift),
        .ifm_out (ifm_out),
        .idle    (idle),
        .finish  (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        ofm_in = '0;
        for (int i = 0; i < MS; i++) begin
            for (int j = 0; j < MS; j++) begin
                ofm_in[(MS*i+j)*BW +: BW] = ofm_arr[i][j];
            end
        end
    end

    task automatic check(input string name, input longint got, input longint want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic int out_el(input int i, input int j);
        logic signed [DW-1:0] v;
        v = ifm_out[(P*i+j)*DW +: DW];
        return int'(v);
    endfunction

    // Reference requantization straight from the arithmetic definition.
    function automatic longint requant(input longint x, input int s_in);
        longint y;
        int     s;
        s = (s_in >= BW) ? BW - 1 : s_in;
        if (s == 0) y = x;
        else        y = (x + (longint'(1) <<< (s - 1))) >>> s;
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
`ifdef REQUANT_RELU_EN
        if (y < 0) y = 0;
`endif
        return y;
    endfunction

    function automatic int model_out(input int i, input int j);
        longint best;
        longint v;
        int     r;
        int     c;
        if (i < PAD || i >= PAD + HALF || j < PAD || j >= PAD + HALF) return 0;
        r    = i - PAD;
        c    = j - PAD;
        best = -1000;
        for (int a = 0; a < 2; a++) begin
            for (int b = 0; b < 2; b++) begin
                v = requant(longint'(cap_ofm[2*r+a][2*c+b]), cap_shift);
                if (v > best) best = v;
            end
        end
        return int'(best);
    endfunction

    // Timeline model: exp_cnt = 0 idle, 1..HALF processing, LAT done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_cnt <= 0;
            for (int i = 0; i < P; i++)
                for (int j = 0; j < P; j++)
                    exp_res[i][j] <= 0;
        end else if (exp_cnt == 0) begin
            if (start) begin
                exp_cnt   <= 1;
                cap_ofm   <= ofm_arr;
                cap_shift <= int'(shift);
            end
        end else if (exp_cnt == LAT) begin
            exp_cnt <= 0;
        end else begin
            exp_cnt <= exp_cnt + 1;
            if (exp_cnt == HALF) begin
                for (int i = 0; i < P; i++)
                    for (int j = 0; j < P; j++)
                        exp_res[i][j] <= model_out(i, j);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("idle", longint'(idle), longint'(exp_cnt == 0));
            check("finish", longint'(finish), longint'(exp_cnt == LAT));
            if (exp_cnt == 0 || exp_cnt == LAT) begin
                int bi;
                int bj;
                bi = -1;
                bj = -1;
                for (int i = 0; i < P; i++)
                    for (int j = 0; j < P; j++)
                        if (bi < 0 && out_el(i, j) != exp_res[i][j]) begin
                            bi = i;
                            bj = j;
                        end
                tests++;
                if (bi >= 0) begin
                    fails++;
                    $display("FAIL ifm_out(%0d,%0d): got %0d, expected %0d",
                             bi, bj, out_el(bi, bj), exp_res[bi][bj]);
                end
            end
        end
    end

    task automatic fill(input int mode);
        for (int i = 0; i < MS; i++) begin
            for (int j = 0; j < MS; j++) begin
                case (mode)
                    0:       ofm_arr[i][j] = BW'($urandom);
                    1:       ofm_arr[i][j] = BW'(int'($urandom_range(0, 2047)) - 1024);
                    default: ofm_arr[i][j] = BW'($signed(BW'($urandom)) >>> $urandom_range(4, 20));
                endcase
            end
        end
    endtask

    task automatic clear_map();
        for (int i = 0; i < MS; i++)
            for (int j = 0; j < MS; j++)
                ofm_arr[i][j] = '0;
    endtask

    task automatic start_op(input int sh);
        @(negedge clk);
        #1;
        start = 1'b1;
        shift = 5'(sh);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns at the falling edge of the finish cycle; lat counts cycles after the accepting edge.
    task automatic run_op(input int sh, input bit inject, output int lat);
        start_op(sh);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (inject && n == 6) begin
                #1;
                start = 1'b0;
            end
            if (finish) begin
                lat = n;
                break;
            end
            if (inject && n == 5) begin
                #1;
                start = 1'b1;
                shift = 5'($urandom);
                fill(0);
            end
        end
        if (lat == 0) check("finish_timeout", 0, LAT);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        start = 1'b0;
        shift = '0;
        clear_map();
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        check("reset_idle", longint'(idle), 1);
        check("reset_finish", longint'(finish), 0);
        check("reset_ifm_out", longint'(ifm_out != '0), 0);

        // All-zero map, shift 0.
        run_op(0, 1'b0, lat);
        check("latency_zero", lat, LAT);
        check("zero_out", longint'(ifm_out != '0), 0);
        @(negedge clk);
        check("idle_after_finish", longint'(idle), 1);

        // Rounding and pooling window values.
        clear_map();
        ofm_arr[0][0] = 26'sd300;  ofm_arr[0][1] = -26'sd5;
        ofm_arr[1][0] = 26'sd7;    ofm_arr[1][1] = 26'sd2;
        ofm_arr[0][2] = 26'sd6;    ofm_arr[0][3] = 26'sd6;
        ofm_arr[1][2] = 26'sd6;    ofm_arr[1][3] = 26'sd6;
        ofm_arr[0][4] = -26'sd6;   ofm_arr[0][5] = -26'sd6;
        ofm_arr[1][4] = -26'sd6;   ofm_arr[1][5] = -26'sd6;
        run_op(2, 1'b0, lat);
        check("pool_75", out_el(1, 1), 75);
        check("tie_pos", out_el(1, 2), 2);
`ifdef REQUANT_RELU_EN
        check("tie_neg", out_el(1, 3), 0);
`else
        check("tie_neg", out_el(1, 3), -1);
`endif
        check("border_00", out_el(0, 0), 0);

        // Saturation.
        clear_map();
        for (int a = 0; a < 2; a++) begin
            for (int b = 0; b < 2; b++) begin
                ofm_arr[a][b]   = 26'sd40000;
                ofm_arr[a][2+b] = -26'sd40000;
            end
        end
        run_op(4, 1'b0, lat);
        check("sat_pos", out_el(1, 1), 127);
`ifdef REQUANT_RELU_EN
        check("sat_neg", out_el(1, 2), 0);
`else
        check("sat_neg", out_el(1, 2), -128);
`endif

        // Random maps; one op carries an ignored start mid-processing, all run back-to-back.
        for (int t = 0; t < 9; t++) begin
            fill(t % 3);
            run_op(int'($urandom_range(0, 31)), (t == 2), lat);
            check("latency_rand", lat, LAT);
        end

        // Reset in the middle of processing.
        fill(2);
        start_op(3);
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_idle", longint'(idle), 1);
        check("midrst_finish", longint'(finish), 0);
        check("midrst_ifm_out", longint'(ifm_out != '0), 0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        fill(1);
        run_op(1, 1'b0, lat);
        check("latency_after_rst", lat, LAT);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
